// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM sequence driver and its result FIFO.
// Latency: none (types and constants only).
// Backpressure: none.
package lstm_pkg;

  // Gate index as carried in cfg_addr[1:0]; also the bit position in each strobe vector.
  typedef enum logic [1:0] {
    GATE_I = 2'd0,
    GATE_F = 2'd1,
    GATE_G = 2'd2,
    GATE_O = 2'd3
  } gate_e;

  // Shadow register type as carried in cfg_addr[3:2].
  typedef enum logic [1:0] {
    CFG_WX = 2'd0,
    CFG_WH = 2'd1,
    CFG_BX = 2'd2,
    CFG_BH = 2'd3
  } cfg_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no open sequence
    ST_RUN  = 2'd1,  // sequence open, cell idle, cell holds its own h/C feedback
    ST_BUSY = 2'd2   // one step in flight inside the cell
  } drv_state_e;

  // Cycles from sample accept to cell_valid.
  localparam int CELL_LATENCY = 7;

endpackage

// File: rtl/lstm_result_fifo.sv
// Synchronous FIFO holding {y, C, last} results.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: push is dropped when full and pop is ignored when empty.
// Ports: push/push_dat write side, pop/pop_dat read side, full/empty flags.
// pop_dat reads as zero while empty so the downstream outputs are quiet after reset.
module lstm_result_fifo #(
  parameter int DAT_W = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DAT_W-1:0] push_dat,
  input  logic             pop,
  output logic [DAT_W-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DAT_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/lstm_seq_driver.sv
// Sequence initiator for the single-cell LSTM: weight push, state injection, result collection.
// Latency: accept at T, cell result at T+7, m_valid at T+8; weight push takes one IDLE cycle.
// Backpressure: a step issues only when the cell is idle and the result FIFO has a free slot.
// Ports: cfg_* shadow-register writes; s_x* sample stream in; cell_* to/from the LSTM cell;
//        m_* result stream out with m_ready backpressure.
// Option: define LSTM_SEQ_INIT_STATE_EN to make h0/C0 writable (cfg_addr[4]=1); otherwise both are 0.
module lstm_seq_driver
  import lstm_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr,
  input  logic [4:0]             cfg_addr,
  input  logic [WIDTH-1:0]       cfg_data,
  input  logic [WIDTH-1:0]       s_x,
  input  logic                   s_x_valid,
  input  logic                   s_x_last,
  output logic                   s_x_ready,
  output logic [3:0][WIDTH-1:0]  cell_weight_x,
  output logic [3:0][WIDTH-1:0]  cell_weight_h,
  output logic [3:0][WIDTH-1:0]  cell_bias_x,
  output logic [3:0][WIDTH-1:0]  cell_bias_h,
  output logic [3:0]             cell_weight_x_valid,
  output logic [3:0]             cell_weight_h_valid,
  output logic [3:0]             cell_bias_x_valid,
  output logic [3:0]             cell_bias_h_valid,
  input  logic                   cell_ready,
  output logic [WIDTH-1:0]       cell_x,
  output logic                   cell_x_valid,
  output logic [WIDTH-1:0]       cell_h,
  output logic                   cell_h_valid,
  output logic [WIDTH-1:0]       cell_C,
  output logic                   cell_C_valid,
  input  logic [WIDTH-1:0]       cell_y,
  input  logic [WIDTH-1:0]       cell_C_out,
  input  logic                   cell_valid,
  output logic [WIDTH-1:0]       m_y,
  output logic [WIDTH-1:0]       m_C,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready
);

  drv_state_e             state;
  logic                   last_q;
  logic [3:0][WIDTH-1:0]  wx_q, wh_q, bx_q, bh_q;
  // Pending bit index is cfg_addr[3:0] = {type, gate}.
  logic [15:0]            pending;
  logic [WIDTH-1:0]       h0_q, c0_q;

  logic                   fifo_full, fifo_empty, fifo_push;
  logic [2*WIDTH:0]       fifo_dout;

  logic                   issue_ok, accept, push_go, cfg_w;
  logic [15:0]            cfg_sel;

  assign issue_ok  = (state == ST_IDLE || state == ST_RUN) && cell_ready && !fifo_full &&
                     (state == ST_RUN || pending == '0);
  assign accept    = s_x_valid && issue_ok;
  assign s_x_ready = issue_ok;

  // Weights only move between sequences, while the cell is idle.
  assign push_go   = (state == ST_IDLE) && cell_ready && (pending != '0);
  assign cfg_w     = cfg_wr && !cfg_addr[4];
  assign cfg_sel   = 16'd1 << cfg_addr[3:0];

  assign cell_weight_x       = wx_q;
  assign cell_weight_h       = wh_q;
  assign cell_bias_x         = bx_q;
  assign cell_bias_h         = bh_q;
  assign cell_weight_x_valid = push_go ? pending[3:0]   : 4'b0;
  assign cell_weight_h_valid = push_go ? pending[7:4]   : 4'b0;
  assign cell_bias_x_valid   = push_go ? pending[11:8]  : 4'b0;
  assign cell_bias_h_valid   = push_go ? pending[15:12] : 4'b0;

  assign cell_x       = s_x;
  assign cell_x_valid = accept;
  assign cell_h       = h0_q;
  assign cell_C       = c0_q;
  // Initial state only on the first sample; in RUN the cell feeds back its own h/C.
  assign cell_h_valid = accept && (state == ST_IDLE);
  assign cell_C_valid = accept && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wx_q    <= '0;
      wh_q    <= '0;
      bx_q    <= '0;
      bh_q    <= '0;
      pending <= '0;
    end else begin
      // A write landing in the push cycle re-arms its bit so the new value goes out next cycle.
      pending <= (push_go ? 16'd0 : pending) | (cfg_w ? cfg_sel : 16'd0);
      if (cfg_w) begin
        case (cfg_type_e'(cfg_addr[3:2]))
          CFG_WX: wx_q[cfg_addr[1:0]] <= cfg_data;
          CFG_WH: wh_q[cfg_addr[1:0]] <= cfg_data;
          CFG_BX: bx_q[cfg_addr[1:0]] <= cfg_data;
          CFG_BH: bh_q[cfg_addr[1:0]] <= cfg_data;
          default: ;
        endcase
      end
    end
  end

`ifdef LSTM_SEQ_INIT_STATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      h0_q <= '0;
      c0_q <= '0;
    end else if (cfg_wr && cfg_addr[4]) begin
      if (cfg_addr[0]) c0_q <= cfg_data;
      else             h0_q <= cfg_data;
    end
  end
`else
  assign h0_q = '0;
  assign c0_q = '0;
`endif

  // cell_valid outside BUSY is stale (e.g. a step dropped by reset) and is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      last_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            last_q <= s_x_last;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cell_valid) begin
            state <= last_q ? ST_IDLE : ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_push = (state == ST_BUSY) && cell_valid;

  lstm_result_fifo #(
    .DAT_W (2*WIDTH+1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat ({cell_y, cell_C_out, last_q}),
    .pop      (m_ready),
    .pop_dat  (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign m_valid            = !fifo_empty;
  assign {m_y, m_C, m_last} = fifo_dout;

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Bench for lstm_seq_driver: directed sequences, a behavioural LSTM-cell stand-in
// (y = x + h, C = C - x, 7-cycle latency) and a per-cycle result/strobe scoreboard.
module tb_lstm_seq_driver;

  localparam int W = 16;

  logic             clk, rst;
  logic             cfg_wr;
  logic [4:0]       cfg_addr;
  logic [W-1:0]     cfg_data;
  logic [W-1:0]     s_x;
  logic             s_x_valid, s_x_last, s_x_ready;
  logic [3:0][W-1:0] cell_weight_x, cell_weight_h, cell_bias_x, cell_bias_h;
  logic [3:0]       cell_weight_x_valid, cell_weight_h_valid, cell_bias_x_valid, cell_bias_h_valid;
  logic             cell_ready;
  logic [W-1:0]     cell_x, cell_h, cell_C;
  logic             cell_x_valid, cell_h_valid, cell_C_valid;
  logic [W-1:0]     cell_y, cell_C_out;
  logic             cell_valid;
  logic [W-1:0]     m_y, m_C;
  logic             m_last, m_valid, m_ready;

  lstm_seq_driver #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_x(s_x), .s_x_valid(s_x_valid), .s_x_last(s_x_last), .s_x_ready(s_x_ready),
    .cell_weight_x(cell_weight_x), .cell_weight_h(cell_weight_h),
    .cell_bias_x(cell_bias_x), .cell_bias_h(cell_bias_h),
    .cell_weight_x_valid(cell_weight_x_valid), .cell_weight_h_valid(cell_weight_h_valid),
    .cell_bias_x_valid(cell_bias_x_valid), .cell_bias_h_valid(cell_bias_h_valid),
    .cell_ready(cell_ready),
    .cell_x(cell_x), .cell_x_valid(cell_x_valid),
    .cell_h(cell_h), .cell_h_valid(cell_h_valid),
    .cell_C(cell_C), .cell_C_valid(cell_C_valid),
    .cell_y(cell_y), .cell_C_out(cell_C_out), .cell_valid(cell_valid),
    .m_y(m_y), .m_C(m_C), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- LSTM cell stand-in ----------------
  logic         acc_s, hv_s;
  logic [W-1:0] x_s, h_s, c_s;
  always @(negedge clk) begin
    acc_s = (cell_x_valid === 1'b1);
    hv_s  = (cell_h_valid === 1'b1);
    x_s   = cell_x;
    h_s   = cell_h;
    c_s   = cell_C;
  end

  // Not reset: a step in flight across a driver reset still emerges, as a real cell would.
  initial begin
    int cnt;
    logic [W-1:0] ch, cc, ry, rc;
    cnt = 0; ch = '0; cc = '0; ry = '0; rc = '0;
    cell_ready = 1'b1; cell_valid = 1'b0; cell_y = '0; cell_C_out = '0;
    forever begin
      @(posedge clk); #1;
      if (acc_s) begin
        if (hv_s) begin ch = h_s; cc = c_s; end
        ry = x_s + ch;
        rc = cc - x_s;
        ch = ry; cc = rc;
        cnt = 1;
        cell_ready = 1'b0;
      end else if (cnt > 0) begin
        cnt++;
        if (cnt == 7) begin
          cell_valid = 1'b1; cell_y = ry; cell_C_out = rc;
        end else if (cnt == 8) begin
          cell_valid = 1'b0; cell_ready = 1'b1; cnt = 0;
        end
      end
    end
  end

  // ---------------- reference model + compare process ----------------
  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] c;
    logic         last;
    int           due;
  } res_t;

  res_t         q[$];
  logic [2*W:0] popped[$];
  int           cyc = 0;
  bit           seq_open = 0;
  logic [W-1:0] h0_ref = '0, c0_ref = '0, rh = '0, rc = '0;
  int           nstrobe = 0, nhv = 0;
  int           last_strobe_cyc = 0, last_acc_cyc = 0, last_pop_cyc = 0;
  logic [3:0]   last_wxv, last_whv, last_bxv, last_bhv;
  logic [3:0][W-1:0] last_wx, last_wh, last_bx;
  logic [W-1:0] last_first_h, last_first_c;

  always @(negedge clk) begin
    bit acc, exp_v;
    logic [W-1:0] ny, nc;
    cyc++;
    acc = (s_x_valid === 1'b1) && (s_x_ready === 1'b1);
    if (rst === 1'b1) begin
      q.delete();
      seq_open = 0;
    end else begin
      // Each accepted step's result must show up exactly 8 cycles later, in order.
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      check("m_valid", m_valid, exp_v);
      if (m_valid === 1'b1 && exp_v) begin
        check("m_dat", {m_y, m_C, m_last}, {q[0].y, q[0].c, q[0].last});
        if (m_ready) begin
          popped.push_back({m_y, m_C, m_last});
          last_pop_cyc = cyc;
          void'(q.pop_front());
        end
      end
      if (|{cell_weight_x_valid, cell_weight_h_valid, cell_bias_x_valid, cell_bias_h_valid}) begin
        nstrobe++;
        last_strobe_cyc = cyc;
        last_wxv = cell_weight_x_valid; last_whv = cell_weight_h_valid;
        last_bxv = cell_bias_x_valid;   last_bhv = cell_bias_h_valid;
        last_wx = cell_weight_x; last_wh = cell_weight_h; last_bx = cell_bias_x;
      end
      if (acc) begin
        last_acc_cyc = cyc;
        check("step_strobes", {cell_x_valid, cell_x, cell_h_valid, cell_C_valid},
              {1'b1, s_x, !seq_open, !seq_open});
        if (cell_h_valid === 1'b1) nhv++;
        if (!seq_open) begin
          check("init_state", {cell_h, cell_C}, {h0_ref, c0_ref});
          last_first_h = cell_h; last_first_c = cell_C;
          rh = h0_ref; rc = c0_ref;
        end
        ny = s_x + rh;
        nc = rc - s_x;
        q.push_back('{y: ny, c: nc, last: s_x_last, due: cyc + 8});
        rh = ny; rc = nc;
        seq_open = !s_x_last;
      end else begin
        check("no_step_strobes", {cell_x_valid, cell_h_valid, cell_C_valid}, 3'b000);
      end
    end
  end

  // ---------------- driver tasks (inputs change 1 time unit after posedge) ----------------
  task automatic cfg(input logic [4:0] a, input logic [W-1:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic last);
    int  n;
    bit  got;
    n = 0; got = 0;
    s_x = x; s_x_last = last; s_x_valid = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      got = (s_x_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    s_x_valid = 1'b0; s_x_last = 1'b0;
    check("send_accepted", got, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", q.size(), 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int s0, hv0;
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    s_x = '0; s_x_valid = 1'b0; s_x_last = 1'b0; m_ready = 1'b1;
    step(3);
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_m", {m_valid, m_y, m_C, m_last}, '0);
    check("rst_strobes", {cell_weight_x_valid, cell_weight_h_valid, cell_bias_x_valid,
                          cell_bias_h_valid, cell_h_valid, cell_C_valid}, '0);
    check("rst_ready", s_x_ready, 1'b1);
    check("rst_shadow", {cell_weight_x, cell_bias_h}, '0);
    step(1);

    // wx[f] push precedes a single-sample sequence.
    s0 = nstrobe;
    cfg(5'b00001, 16'h0100);
    send(16'h0080, 1'b1);
    drain();
    check("push_count", nstrobe - s0, 1);
    check("push_vec", {last_wxv, last_whv, last_bxv, last_bhv}, 16'h2000);
    check("push_val", last_wx[1], 16'h0100);
    check("push_before_acc", last_acc_cyc - last_strobe_cyc, 1);
    check("latency8", last_pop_cyc - last_acc_cyc, 8);
    check("single_res", popped[popped.size()-1], {16'h0080, 16'hFF80, 1'b1});

    // 3-sample sequence: h/C injected once, last only on the third result.
    hv0 = nhv;
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b0);
    send(16'h0030, 1'b1);
    drain();
    check("hv_once", nhv - hv0, 1);
    check("seq3_r0", popped[popped.size()-3], {16'h0010, 16'hFFF0, 1'b0});
    check("seq3_r1", popped[popped.size()-2], {16'h0030, 16'hFFD0, 1'b0});
    check("seq3_r2", popped[popped.size()-1], {16'h0060, 16'hFFA0, 1'b1});

    // FIFO full blocks issue; one pop lets the next sample go the following cycle.
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
    s_x = 16'd5; s_x_last = 1'b0; s_x_valid = 1'b1;
    step(30);
    @(negedge clk);
    check("full_blocks", {s_x_ready, m_valid}, 2'b01);
    step(1);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    send(16'd5, 1'b0);
    check("resume_after_pop", last_acc_cyc - last_pop_cyc, 1);
    m_ready = 1'b1;
    send(16'd6, 1'b1);
    drain();
    check("bp_last", popped[popped.size()-1], {16'h0015, 16'hFFEB, 1'b1});

    // Config write mid-sequence waits until the sequence closes.
    s0 = nstrobe;
    send(16'h0011, 1'b0);
    cfg(5'b01011, 16'h0ABC);
    send(16'h0022, 1'b1);
    drain();
    step(3);
    check("busy_push_count", nstrobe - s0, 1);
    check("busy_push_vec", {last_wxv, last_whv, last_bxv, last_bhv}, 16'h0080);
    check("busy_push_val", last_bx[3], 16'h0ABC);
    check("busy_push_when", last_strobe_cyc - last_acc_cyc, 8);

    // Rewrite of the same register in its push cycle re-pushes the new value.
    s0 = nstrobe;
    cfg(5'b00110, 16'h1111);
    cfg(5'b00110, 16'h2222);
    step(3);
    check("repush_count", nstrobe - s0, 2);
    check("repush_vec", last_whv, 4'b0100);
    check("repush_val", last_wh[2], 16'h2222);

    // Reset mid-step: the late cell_valid is discarded and the driver is back in IDLE.
    send(16'h0100, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    @(negedge clk);
    check("rst_drop", m_valid, 1'b0);
    step(1);
    hv0 = nhv;
    send(16'h0200, 1'b1);
    drain();
    check("rst_idle_hv", nhv - hv0, 1);
    check("rst_next_res", popped[popped.size()-1], {16'h0200, 16'hFE00, 1'b1});

    // Initial state writes.
    cfg(5'b10000, 16'h0040);
    cfg(5'b10001, 16'hFF80);
`ifdef LSTM_SEQ_INIT_STATE_EN
    h0_ref = 16'h0040; c0_ref = 16'hFF80;
`endif
    send(16'h0008, 1'b1);
    drain();
`ifdef LSTM_SEQ_INIT_STATE_EN
    check("init_h_c", {last_first_h, last_first_c}, {16'h0040, 16'hFF80});
    check("init_res", popped[popped.size()-1], {16'h0048, 16'hFF78, 1'b1});
`else
    check("init_h_c", {last_first_h, last_first_c}, 32'h0);
    check("init_res", popped[popped.size()-1], {16'h0008, 16'hFFF8, 1'b1});
`endif

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/lstm_seq_driver.md
# lstm_seq_driver

Sequence controller that sits upstream of the single-cell LSTM datapath and acts as its initiator. Accepts a stream of input samples with end-of-sequence marking, programs gate weights and biases into the cell between sequences, injects the initial hidden/cell state at each sequence start, and collects each step's `y`/`C` into a small output FIFO with downstream backpressure. The cell has no output backpressure, so this block issues a step only when the result is guaranteed a FIFO slot.

## Interface
- `WIDTH`, 16: sample, weight and state width, signed Q8.8.
- `FIFO_DEPTH`, 4: result FIFO entries, power of two, ≥2.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `cfg_wr`  in  1: config write strobe.
- `cfg_addr`  in  5: `[4]=0`: `[3:2]` type (0 wx, 1 wh, 2 bx, 3 bh), `[1:0]` gate (0 i, 1 f, 2 g, 3 o). `[4]=1`: `[0]` selects h0 (0) or C0 (1).
- `cfg_data`  in  WIDTH: config value.
- `s_x`, `s_x_valid`, `s_x_last`  in  WIDTH/1/1: input sample stream.
- `s_x_ready`  out  1: sample accepted when `s_x_valid && s_x_ready`.
- `cell_weight_x`, `cell_weight_h`, `cell_bias_x`, `cell_bias_h`  out  4×WIDTH each: shadow values to cell.
- `cell_weight_x_valid`, `cell_weight_h_valid`, `cell_bias_x_valid`, `cell_bias_h_valid`  out  4 each: per-gate load strobes.
- `cell_ready`  in  1: cell idle.
- `cell_x`, `cell_x_valid`  out  WIDTH/1: step sample.
- `cell_h`, `cell_h_valid`, `cell_C`, `cell_C_valid`  out  WIDTH/1 each: initial state.
- `cell_y`, `cell_C_out`, `cell_valid`  in  WIDTH/WIDTH/1: step result.
- `m_y`, `m_C`, `m_last`, `m_valid`  out  WIDTH/WIDTH/1/1: result stream.
- `m_ready`  in  1: downstream accept.

## Operation
- Shadow registers: 16 weight/bias regs, each with a pending bit; `cfg_wr` writes the value and sets pending. Config writes are accepted in any state.
- Weight push: in IDLE with `cell_ready=1` and any pending bit set, all pending strobes are asserted for exactly one cycle, then cleared. A `cfg_wr` to the same address in the push cycle leaves pending set; the new value is pushed next cycle.
- `issue_ok = (state==IDLE || state==RUN) && cell_ready && !fifo_full && (state==RUN || pending==0)`.
- `s_x_ready = issue_ok`; `cell_x = s_x`; `cell_x_valid = s_x_valid && issue_ok`.
- States:
  - IDLE: no open sequence. On accept: assert `cell_h_valid`/`cell_C_valid` with h0/C0, latch `s_x_last`, go to BUSY.
  - RUN: sequence open; the cell supplies its own feedback, and h/C valid strobes stay low. On accept: latch last, go to BUSY.
  - BUSY: wait for `cell_valid`, then push `{cell_y, cell_C_out, last}` and go to IDLE if last, else RUN.
- A single-sample sequence (`s_x_last=1` on the first sample) goes IDLE→BUSY→IDLE.
- `cell_valid` outside BUSY is ignored and not pushed. This covers stale cell pipeline contents after a reset mid-step.
- No arithmetic is performed; all values pass through unmodified.

## Timing
- Reset values: state IDLE, FIFO empty, pending=0, shadow regs, h0 and C0 = 0, all cell strobes 0, `m_valid=0`, `m_y=m_C=0`, `m_last=0`.
- Accept at cycle T. `cell_valid` at T+7 (cell latency). FIFO write at the T+7 edge, so `m_valid` rises at T+8.
- Next accept at T+8 at the earliest, when `cell_ready` returns high.
- FIFO: simultaneous push and pop at full is not possible because issue is blocked at full. Simultaneous push and pop at empty is allowed; the pushed entry appears the next cycle.
- `m_*` hold stable while `m_valid && !m_ready`.
- A reset mid-sequence drops the in-flight step and all FIFO contents.

## Configuration
- `LSTM_SEQ_INIT_STATE_EN`
  - Defined: h0 and C0 are writable via `cfg_addr[4]=1`.
  - Undefined: h0 and C0 are fixed at 0, and writes with `cfg_addr[4]=1` are ignored.

## Structure
- Shared package `lstm_pkg`:
  - gate enum {i, f, g, o}
  - cfg type enum {WX, WH, BX, BH}
  - driver state enum
  - `CELL_LATENCY=7`
- Sub-module `lstm_result_fifo`: synchronous FIFO, width 2·WIDTH+1, with full/empty flags.

## Test plan
- Write wx[f]=0x0100, then one sample 0x0080 with last. Expect `cell_weight_x_valid=4'b0010` for one cycle before the accept, `cell_h_valid`/`cell_C_valid` with 0, and `m_valid` 8 cycles after accept with `m_last=1`.
- 3-sample sequence. Expect h/C valid only on the first sample, three results, and `m_last` only on the third.
- Hold `m_ready=0` with FIFO_DEPTH=4 over a 6-sample sequence. Expect `s_x_ready` to stay low after 4 results; after draining one result, issue resumes.
- `cfg_wr` during BUSY. Expect no strobe until the sequence closes in IDLE, then a one-cycle push.
- Assert `rst` at accept+3 and inject `cell_valid` at +7. Expect no FIFO push and state IDLE.
- With `LSTM_SEQ_INIT_STATE_EN`, write h0=0x0040 and C0=0xFF80. Expect `cell_h=0x0040` and `cell_C=0xFF80` on the first sample.
